processor_pio_pulse: RTL and testbench

PROCESSOR_PIO_PULSE -- requirements
Module: processor_pio_pulse

---
 rtl/processor_pio_pulse.sv | 154 +++++++++++++++
 tb/tb_processor_pio_pulse.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/processor_pio_pulse.sv
`default_nettype none
// ============================================================================
// Module      : processor_pio_pulse
// Description : Avalon-MM parallel output port with SET/CLEAR aliases and an
//               optional one-shot pulse engine that XOR-inverts a mask of
//               output bits for a programmed number of clock cycles.
//               Optional feature macro: PROCESSOR_PIO_PULSE_EN
//               (undefined -> plain PIO, pulse registers read 0).
// Revision    : 1.0 - initial release
// ============================================================================
module processor_pio_pulse #(
  parameter int unsigned WIDTH       = 8,
  parameter logic [31:0] RESET_VALUE = 32'h0,
  parameter int unsigned PULSE_CNT_W = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [2:0]        address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic [WIDTH-1:0]  out_port,
  output logic              pulse_busy
);

  localparam logic [2:0] ADDR_DATA   = 3'd0;
  localparam logic [2:0] ADDR_PLEN   = 3'd2;
  localparam logic [2:0] ADDR_STATUS = 3'd3;
  localparam logic [2:0] ADDR_OUTSET = 3'd4;
  localparam logic [2:0] ADDR_OUTCLR = 3'd5;
  localparam logic [2:0] ADDR_PULSE  = 3'd6;

  logic             w_wr;
  logic [WIDTH-1:0] w_wdata;
  logic [WIDTH-1:0] data_d;
  logic [WIDTH-1:0] data_q;
  logic             w_unused_ok;

  assign w_wr        = chipselect & ~write_n;
  assign w_wdata     = writedata[WIDTH-1:0];
  assign w_unused_ok = ^writedata;

  // DATA register next state: plain write, bitwise set, bitwise clear
  always_comb begin
    data_d = data_q;
    if (w_wr) begin
      case (address)
        ADDR_DATA:   data_d = w_wdata;
        ADDR_OUTSET: data_d = data_q | w_wdata;
        ADDR_OUTCLR: data_d = data_q & ~w_wdata;
        default:     data_d = data_q;
      endcase
    end
  end

  // DATA register storage
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) data_q <= RESET_VALUE[WIDTH-1:0];
    else          data_q <= data_d;
  end

`ifdef PROCESSOR_PIO_PULSE_EN
  // Pulse engine state is implied by the counter: zero means idle.
  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_ACTIVE = 1'b1;

  logic [PULSE_CNT_W-1:0] plen_d, plen_q;
  logic [PULSE_CNT_W-1:0] cnt_d, cnt_q;
  logic [WIDTH-1:0]       mask_d, mask_q;
  logic                   done_d, done_q;
  logic                   ovr_d, ovr_q;
  logic [0:0]             w_state;
  logic                   w_pulse_wr;
  logic                   w_last;
  logic                   w_status_wr;

  assign w_state     = (cnt_q != '0) ? ST_ACTIVE : ST_IDLE;
  assign w_pulse_wr  = w_wr && (address == ADDR_PULSE);
  assign w_status_wr = w_wr && (address == ADDR_STATUS);
  // Final active cycle: the counter goes 1 -> 0 on the coming edge
  assign w_last      = (w_state == ST_ACTIVE) && (cnt_q == PULSE_CNT_W'(1));

  // Pulse engine next state; hardware sets win over same-edge W1C clears
  always_comb begin
    plen_d = plen_q;
    cnt_d  = cnt_q;
    mask_d = mask_q;
    done_d = done_q;
    ovr_d  = ovr_q;
    if (w_wr && (address == ADDR_PLEN))
      plen_d = writedata[PULSE_CNT_W-1:0];
    case (w_state)
      ST_IDLE: begin
        if (w_pulse_wr && (plen_q != '0)) begin
          cnt_d  = plen_q;
          mask_d = w_wdata;
        end
      end
      default: begin
        cnt_d = cnt_q - PULSE_CNT_W'(1);
        if (w_last) mask_d = '0;
      end
    endcase
    if (w_status_wr && writedata[1]) done_d = 1'b0;
    if (w_last)                      done_d = 1'b1;
    if (w_status_wr && writedata[2]) ovr_d  = 1'b0;
    if (w_pulse_wr && (w_state == ST_ACTIVE)) ovr_d = 1'b1;
  end

  // Pulse engine storage; reset aborts any pulse without flagging done
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      plen_q <= '0;
      cnt_q  <= '0;
      mask_q <= '0;
      done_q <= 1'b0;
      ovr_q  <= 1'b0;
    end else begin
      plen_q <= plen_d;
      cnt_q  <= cnt_d;
      mask_q <= mask_d;
      done_q <= done_d;
      ovr_q  <= ovr_d;
    end
  end

  // Zero-wait-state read mux with zero-extended fields
  always_comb begin
    readdata = '0;
    case (address)
      ADDR_DATA:   readdata[WIDTH-1:0]       = data_q;
      ADDR_PLEN:   readdata[PULSE_CNT_W-1:0] = plen_q;
      ADDR_STATUS: readdata[2:0]             = {ovr_q, done_q, (w_state == ST_ACTIVE)};
      default:     readdata = '0;
    endcase
  end

  // MASK is zero whenever idle, so the XOR alone selects the output
  assign out_port   = data_q ^ mask_q;
  assign pulse_busy = (w_state == ST_ACTIVE);
`else
  // Plain PIO read mux: only DATA is readable
  always_comb begin
    readdata = '0;
    if (address == ADDR_DATA) readdata[WIDTH-1:0] = data_q;
  end

  assign out_port   = data_q;
  assign pulse_busy = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_processor_pio_pulse.sv
`default_nettype none
// ============================================================================
// Module      : tb_processor_pio_pulse
// Description : Directed self-checking bench for processor_pio_pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_processor_pio_pulse;

  localparam logic [7:0] RV = 8'h3C;

  logic        clk;
  logic        reset_n;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [7:0]  out_port;
  logic        pulse_busy;

  int n_tests;
  int n_fail;
  logic [31:0] rd;

  processor_pio_pulse #(
    .WIDTH(8),
    .RESET_VALUE({24'h0, RV}),
    .PULSE_CNT_W(16)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .address(address),
    .chipselect(chipselect),
    .write_n(write_n),
    .writedata(writedata),
    .readdata(readdata),
    .out_port(out_port),
    .pulse_busy(pulse_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One bus write: takes effect on the next rising edge; returns 1 ns after it
  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(posedge clk);
    #1;
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
    address = a;
    #1;
    d = readdata;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    #1;
    n_tests++;
    if (out_port !== RV) begin
      n_fail++;
      $display("FAIL reset_out_port: got %h expected %h", out_port, RV);
    end
    n_tests++;
    if (pulse_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_busy: got %b expected 0", pulse_busy);
    end
    for (int a = 0; a < 8; a++) begin
      bus_read(3'(a), rd);
      n_tests++;
      if (rd !== ((a == 0) ? {24'h0, RV} : 32'h0)) begin
        n_fail++;
        $display("FAIL reset_read_addr%0d: got %h expected %h", a, rd,
                 (a == 0) ? {24'h0, RV} : 32'h0);
      end
    end
    step();
    reset_n = 1'b1;
    step();
  endtask

  task automatic test_set_clear();
    bus_write(3'd0, 32'h0000_00A5);
    n_tests++;
    if (out_port !== 8'hA5) begin
      n_fail++;
      $display("FAIL data_write: got %h expected a5", out_port);
    end
    bus_write(3'd4, 32'h0000_000F);
    n_tests++;
    if (out_port !== 8'hAF) begin
      n_fail++;
      $display("FAIL outset: got %h expected af", out_port);
    end
    bus_write(3'd5, 32'h0000_0081);
    n_tests++;
    if (out_port !== 8'h2E) begin
      n_fail++;
      $display("FAIL outclear: got %h expected 2e", out_port);
    end
    bus_read(3'd0, rd);
    n_tests++;
    if (rd !== 32'h0000_002E) begin
      n_fail++;
      $display("FAIL data_readback: got %h expected 0000002e", rd);
    end
  endtask

`ifdef PROCESSOR_PIO_PULSE_EN
  task automatic test_pulse();
    bus_write(3'd0, 32'h0);
    bus_write(3'd2, 32'd3);
    bus_write(3'd6, 32'h11);
    for (int i = 0; i < 3; i++) begin
      n_tests++;
      if (out_port !== 8'h11 || pulse_busy !== 1'b1) begin
        n_fail++;
        $display("FAIL pulse_active_cycle%0d: got out=%h busy=%b expected out=11 busy=1",
                 i, out_port, pulse_busy);
      end
      step();
    end
    n_tests++;
    if (out_port !== 8'h00 || pulse_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL pulse_end: got out=%h busy=%b expected out=00 busy=0", out_port, pulse_busy);
    end
    bus_read(3'd3, rd);
    n_tests++;
    if (rd !== 32'h2) begin
      n_fail++;
      $display("FAIL pulse_done: got status %h expected 00000002", rd);
    end
    bus_write(3'd3, 32'h2);
    bus_read(3'd3, rd);
    n_tests++;
    if (rd !== 32'h0) begin
      n_fail++;
      $display("FAIL done_w1c: got status %h expected 00000000", rd);
    end
  endtask

  task automatic test_overrun();
    bus_write(3'd2, 32'd5);
    bus_write(3'd6, 32'h01);
    for (int i = 0; i < 5; i++) begin
      n_tests++;
      if (out_port !== 8'h01) begin
        n_fail++;
        $display("FAIL overrun_cycle%0d: got %h expected 01", i, out_port);
      end
      if (i == 1) bus_write(3'd6, 32'h80);
      else        step();
    end
    n_tests++;
    if (out_port !== 8'h00) begin
      n_fail++;
      $display("FAIL overrun_end: got %h expected 00", out_port);
    end
    bus_read(3'd3, rd);
    n_tests++;
    if (rd !== 32'h6) begin
      n_fail++;
      $display("FAIL overrun_status: got %h expected 00000006", rd);
    end
    bus_write(3'd3, 32'h6);
  endtask

  task automatic test_zero_len();
    bus_write(3'd2, 32'd0);
    bus_write(3'd6, 32'hFF);
    n_tests++;
    if (out_port !== 8'h00 || pulse_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_len: got out=%h busy=%b expected out=00 busy=0", out_port, pulse_busy);
    end
    bus_read(3'd3, rd);
    n_tests++;
    if (rd !== 32'h0) begin
      n_fail++;
      $display("FAIL zero_len_status: got %h expected 00000000", rd);
    end
  endtask

  task automatic test_data_during_pulse();
    bus_write(3'd2, 32'd3);
    bus_write(3'd6, 32'h0F);
    bus_write(3'd4, 32'hF0);
    n_tests++;
    if (out_port !== 8'hFF) begin
      n_fail++;
      $display("FAIL outset_during_pulse: got %h expected ff", out_port);
    end
    step();
    step();
    n_tests++;
    if (out_port !== 8'hF0 || pulse_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL outset_after_pulse: got out=%h busy=%b expected out=f0 busy=0",
               out_port, pulse_busy);
    end
    bus_write(3'd3, 32'h2);
    bus_write(3'd0, 32'h0);
  endtask

  task automatic test_reset_mid_pulse();
    bus_write(3'd2, 32'd10);
    bus_write(3'd6, 32'h0F);
    step();
    step();
    step();
    n_tests++;
    if (out_port !== 8'h0F) begin
      n_fail++;
      $display("FAIL midreset_pre: got %h expected 0f", out_port);
    end
    reset_n = 1'b0;
    #1;
    n_tests++;
    if (out_port !== RV || pulse_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_abort: got out=%h busy=%b expected out=%h busy=0",
               out_port, pulse_busy, RV);
    end
    step();
    reset_n = 1'b1;
    step();
    step();
    bus_read(3'd3, rd);
    n_tests++;
    if (rd !== 32'h0 || out_port !== RV) begin
      n_fail++;
      $display("FAIL midreset_after: got status=%h out=%h expected status=00000000 out=%h",
               rd, out_port, RV);
    end
  endtask
`else
  task automatic test_disabled();
    bus_write(3'd0, 32'h0);
    bus_write(3'd2, 32'd4);
    bus_write(3'd6, 32'hFF);
    for (int i = 0; i < 3; i++) begin
      n_tests++;
      if (out_port !== 8'h00 || pulse_busy !== 1'b0) begin
        n_fail++;
        $display("FAIL disabled_pulse_cycle%0d: got out=%h busy=%b expected out=00 busy=0",
                 i, out_port, pulse_busy);
      end
      step();
    end
    bus_read(3'd2, rd);
    n_tests++;
    if (rd !== 32'h0) begin
      n_fail++;
      $display("FAIL disabled_plen_read: got %h expected 00000000", rd);
    end
    bus_read(3'd3, rd);
    n_tests++;
    if (rd !== 32'h0) begin
      n_fail++;
      $display("FAIL disabled_status_read: got %h expected 00000000", rd);
    end
  endtask
`endif

  initial begin
    n_tests    = 0;
    n_fail     = 0;
    reset_n    = 1'b0;
    address    = 3'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = 32'h0;
    step();
    test_reset();
    test_set_clear();
`ifdef PROCESSOR_PIO_PULSE_EN
    test_pulse();
    test_overrun();
    test_zero_len();
    test_data_during_pulse();
    test_reset_mid_pulse();
`else
    test_disabled();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
